// File: rtl/instr_encoder.sv
// Packs opcode/operand field sets into 16-bit instruction words and writes them
// sequentially into program memory, tracking word count, fullness and illegal opcodes.
module instr_encoder #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [5:0]        in_ri,
  input  logic [5:0]        in_rj,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              full,
  output logic              err_illegal
);

  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, ENC, WR} state_t;

  state_t      state_q, state_d;
  logic [3:0]  op_q;
  logic [5:0]  ri_q, rj_q;
  logic [15:0] word;
  logic        legal;

  assign full = (word_count == CNT_W'(DEPTH));

  // NOTE: every output of a combinational block gets a default first, so no path
  // through the case leaves it unassigned and a latch is never inferred.
  always_comb begin
    word  = {op_q, ri_q, rj_q};
    legal = 1'b1;
    unique case (op_q)
      4'b0000:          word = 16'h0000;
      4'b0101:          word = {4'b0101, 6'b0, ri_q};  // decoder reads NOT operand from [5:0]
      4'b0110, 4'b1110: legal = 1'b0;
      default:          word = {op_q, ri_q, rj_q};
    endcase
  end

  // State register
  // NOTE: sequential state is always written with non-blocking assignments so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; clear overrides everything and aborts ENC/WR.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (in_valid && in_ready) state_d = ENC;
        ENC:     state_d = legal ? WR : IDLE;
        WR:      state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    in_ready = (state_q == IDLE) && !full && !clear;
    mem_we   = (state_q == WR) && !clear;
  end

  // Datapath: field latches, encoded word, address, count and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= '0;
      ri_q        <= '0;
      rj_q        <= '0;
      mem_wdata   <= '0;
      mem_addr    <= '0;
      word_count  <= '0;
      err_illegal <= 1'b0;
    end else if (clear) begin
      mem_addr    <= '0;
      word_count  <= '0;
      err_illegal <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (in_valid && in_ready) begin
          op_q <= in_op;
          ri_q <= in_ri;
          rj_q <= in_rj;
        end
        ENC: begin
          if (legal) mem_wdata   <= word;
          else       err_illegal <= 1'b1;
        end
        WR: begin
          // Natural ADDR_W-bit wrap; only reachable when DEPTH == 2**ADDR_W.
          mem_addr   <= mem_addr + ADDR_W'(1);
          word_count <= word_count + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder (DEPTH=4, ADDR_W=2): stimulus pushes expected
// writes, a negedge monitor pops and compares every mem_we strobe.
module tb_instr_encoder;

  localparam int ADDR_W = 2;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clear = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [3:0]        in_op = '0;
  logic [5:0]        in_ri = '0;
  logic [5:0]        in_rj = '0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [ADDR_W:0]   word_count;
  logic              full;
  logic              err_illegal;

  instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_ri(in_ri), .in_rj(in_rj),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .word_count(word_count), .full(full), .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
  } wr_t;

  wr_t   sb_q[$];
  int    wr_cyc[$];
  int    n_cmp = 0;
  int    n_fail = 0;
  int    cyc = 0;
  logic [ADDR_W-1:0] exp_addr = '0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      wr_cyc.push_back(cyc);
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: addr %0h data %0h, none expected", mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = sb_q.pop_front();
        if (mem_addr !== e.addr || mem_wdata !== e.data) begin
          n_fail++;
          $display("FAIL write: got addr %0h data %0h expected addr %0h data %0h",
                   mem_addr, mem_wdata, e.addr, e.data);
        end
      end
    end
  end

  // Offer one field set; wait (bounded) for acceptance, then follow ENC and WR.
  task automatic send(input logic [3:0] op, input logic [5:0] ri, input logic [5:0] rj,
                      input logic [15:0] exp_word, input bit legal, input bit hold);
    bit acc;
    int budget;
    in_op = op; in_ri = ri; in_rj = rj; in_valid = 1'b1;
    acc = 0; budget = 0;
    while (!acc && budget < 50) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      budget++;
    end
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
    if (!hold) in_valid = 1'b0;
    if (legal) begin
      sb_q.push_back('{addr: exp_addr, data: exp_word});
      exp_addr = exp_addr + ADDR_W'(1);
    end
    @(negedge clk); check("enc_no_we", {31'd0, mem_we}, 32'd0);
    check("enc_not_ready", {31'd0, in_ready}, 32'd0);
    if (legal) begin
      @(negedge clk); check("wr_we_latency", {31'd0, mem_we}, 32'd1);
    end
    @(posedge clk); #1;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    exp_addr = '0;
  endtask

  initial begin
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    // Reset state
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_addr", {30'd0, mem_addr}, 32'd0);
    check("rst_wdata", {16'd0, mem_wdata}, 32'd0);
    check("rst_count", {29'd0, word_count}, 32'd0);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_err", {31'd0, err_illegal}, 32'd0);

    // Basic encoding: reg-reg ALU, NOT, NOP with non-zero operands
    send(4'b0001, 6'd3, 6'd5, 16'h10C5, 1, 0);
    check("count_after_1", {29'd0, word_count}, 32'd1);
    send(4'b0101, 6'd9, 6'd7, 16'h5009, 1, 0);
    send(4'b0000, 6'd63, 6'd63, 16'h0000, 1, 0);

    // Illegal opcode: no write, sticky error, count unchanged
    send(4'b0110, 6'd1, 6'd1, 16'h0000, 0, 0);
    check("illegal_err", {31'd0, err_illegal}, 32'd1);
    check("illegal_count", {29'd0, word_count}, 32'd3);
    check("illegal_addr", {30'd0, mem_addr}, 32'd3);

    // Fourth word fills memory; address wraps since DEPTH == 2**ADDR_W
    send(4'b0111, 6'd1, 6'd2, 16'h7042, 1, 0);
    check("full_flag", {31'd0, full}, 32'd1);
    check("full_ready", {31'd0, in_ready}, 32'd0);
    check("full_count", {29'd0, word_count}, 32'd4);
    check("full_addr_wrap", {30'd0, mem_addr}, 32'd0);
    check("err_still_set", {31'd0, err_illegal}, 32'd1);

    // Fifth offer while full is ignored
    in_op = 4'b0001; in_valid = 1'b1;
    repeat (6) @(posedge clk);
    #1 in_valid = 1'b0;
    check("full_no_accept_count", {29'd0, word_count}, 32'd4);

    pulse_clear();
    check("clr_full", {31'd0, full}, 32'd0);
    check("clr_addr", {30'd0, mem_addr}, 32'd0);
    check("clr_count", {29'd0, word_count}, 32'd0);
    check("clr_err", {31'd0, err_illegal}, 32'd0);

    // Clear during WR aborts the write
    in_op = 4'b1001; in_ri = 6'd2; in_rj = 6'd3; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;   // accepted (IDLE, ready)
    @(posedge clk); #1;                   // now in WR
    clear = 1'b1;
    @(negedge clk); check("clr_in_wr_we", {31'd0, mem_we}, 32'd0);
    @(posedge clk); #1 clear = 1'b0;
    check("clr_in_wr_count", {29'd0, word_count}, 32'd0);
    check("clr_in_wr_addr", {30'd0, mem_addr}, 32'd0);

    // One real write, then async reset while the next word is in ENC
    send(4'b1100, 6'd4, 6'd8, 16'hC108, 1, 0);
    in_op = 4'b1101; in_ri = 6'd1; in_rj = 6'd1; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;   // accepted, now ENC
    #2 rst_n = 1'b0;
    #1;
    check("arst_we", {31'd0, mem_we}, 32'd0);
    check("arst_ready", {31'd0, in_ready}, 32'd1);
    check("arst_count", {29'd0, word_count}, 32'd0);
    check("arst_addr", {30'd0, mem_addr}, 32'd0);
    check("arst_wdata", {16'd0, mem_wdata}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    exp_addr = '0;
    @(posedge clk); #1;

    // Held in_valid: immediate ops, writes exactly 3 cycles apart
    wr_cyc.delete();
    send(4'b0010, 6'd1, 6'd42, 16'h206A, 1, 1);
    send(4'b0100, 6'd2, 6'd3,  16'h4083, 1, 1);
    send(4'b1011, 6'd4, 6'd63, 16'hB13F, 1, 0);
    check("held_writes", wr_cyc.size(), 32'd3);
    if (wr_cyc.size() == 3) begin
      check("spacing_0_1", wr_cyc[1] - wr_cyc[0], 32'd3);
      check("spacing_1_2", wr_cyc[2] - wr_cyc[1], 32'd3);
    end

    repeat (4) @(posedge clk);
    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
